external_bus_responder: RTL and testbench

- Sits between the CPU core's external pins and a single-outstanding request/acknowledge memory port.
- Captures each access the core presents (16-bit address, R/W, write data) and stalls the core with a ready signal while the access is in flight.
- Runs the downstream handshake, and returns read data on the byte the core samples as external data-bus input.
- This is the servicing end of the core's external address/data bus.

---
 rtl/external_bus_responder.sv | 138 +++++++++++++
 tb/tb_external_bus_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/external_bus_responder.sv
// Servicing end of the core's external address/data bus: captures each access, runs a single-outstanding
// request/ack memory handshake, and returns read data. Optional timeout abort under RESPONDER_TIMEOUT_EN.
module external_bus_responder #(
  parameter int unsigned TIMEOUT_CYCLES     = 16,
  parameter logic [7:0]  TIMEOUT_READ_VALUE = 8'hEA
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  cpuAddressLow,
  input  logic [7:0]  cpuAddressHigh,
  input  logic [7:0]  cpuDataWrite,
  input  logic        cpuWrite,
  input  logic        cpuRequest,
  output logic        cpuReady,
  output logic [7:0]  cpuDataRead,
  output logic [15:0] memAddress,
  output logic [7:0]  memWriteData,
  output logic        memWrite,
  output logic        memRequest,
  input  logic        memAck,
  input  logic [7:0]  memReadData,
  output logic        busError
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_REQUEST = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_capture;
  logic        w_ack_done;
  logic [15:0] r_mem_address;
  logic [7:0]  r_mem_write_data;
  logic        r_mem_write;
  logic [7:0]  r_cpu_data_read;

`ifdef RESPONDER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic       w_abort;
  logic [7:0] r_count;
  logic       r_bus_error;
`else
  wire w_unused_params = ^{TIMEOUT_READ_VALUE, 8'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An ack on the same edge as timeout expiry takes priority over the abort.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_ack_done   = 1'b0;
`ifdef RESPONDER_TIMEOUT_EN
    w_abort      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (cpuRequest) begin
          w_capture    = 1'b1;
          w_state_next = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (memAck) begin
          w_ack_done   = 1'b1;
          w_state_next = S_IDLE;
        end
`ifdef RESPONDER_TIMEOUT_EN
        else if (r_count == TIMEOUT_LAST) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mem_address    <= 16'h0000;
      r_mem_write_data <= 8'h00;
      r_mem_write      <= 1'b0;
      r_cpu_data_read  <= 8'h00;
    end else begin
      if (w_capture) begin
        r_mem_address    <= {cpuAddressHigh, cpuAddressLow};
        r_mem_write_data <= cpuDataWrite;
        r_mem_write      <= cpuWrite;
      end
      if (w_ack_done && !r_mem_write) begin
        r_cpu_data_read <= memReadData;
      end
`ifdef RESPONDER_TIMEOUT_EN
      if (w_abort && !r_mem_write) begin
        r_cpu_data_read <= TIMEOUT_READ_VALUE;
      end
`endif
    end
  end

`ifdef RESPONDER_TIMEOUT_EN
  // Counter only advances while the access stays pending, so it never wraps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count     <= 8'h00;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= w_abort;
      if (w_capture) begin
        r_count <= 8'h00;
      end else if (r_state == S_REQUEST && !w_ack_done && !w_abort) begin
        r_count <= r_count + 8'h01;
      end
    end
  end

  assign busError = r_bus_error;
`else
  assign busError = 1'b0;
`endif

  assign cpuReady     = (r_state == S_IDLE);
  assign memRequest   = (r_state == S_REQUEST);
  assign memAddress   = r_mem_address;
  assign memWriteData = r_mem_write_data;
  assign memWrite     = r_mem_write;
  assign cpuDataRead  = r_cpu_data_read;

endmodule

// File: tb/tb_external_bus_responder.sv
// Scoreboard bench for external_bus_responder: directed and random accesses against a memory-level model.
module tb_external_bus_responder;
  localparam int unsigned T = 16;
`ifdef RESPONDER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  cpuAddressLow = 8'h00;
  logic [7:0]  cpuAddressHigh = 8'h00;
  logic [7:0]  cpuDataWrite = 8'h00;
  logic        cpuWrite = 1'b0;
  logic        cpuRequest = 1'b0;
  logic        cpuReady;
  logic [7:0]  cpuDataRead;
  logic [15:0] memAddress;
  logic [7:0]  memWriteData;
  logic        memWrite;
  logic        memRequest;
  logic        memAck = 1'b0;
  logic [7:0]  memReadData = 8'h00;
  logic        busError;

  always #5 clk = ~clk;

  external_bus_responder #(.TIMEOUT_CYCLES(T), .TIMEOUT_READ_VALUE(8'hEA)) dut (
    .clk(clk), .nrst(nrst),
    .cpuAddressLow(cpuAddressLow), .cpuAddressHigh(cpuAddressHigh),
    .cpuDataWrite(cpuDataWrite), .cpuWrite(cpuWrite), .cpuRequest(cpuRequest),
    .cpuReady(cpuReady), .cpuDataRead(cpuDataRead),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
    .memRequest(memRequest), .memAck(memAck), .memReadData(memReadData),
    .busError(busError)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [bit [15:0]];
  logic [7:0] last_read = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] mem_value(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // Issue one access; w = cycles of ack delay after the first REQUEST edge.
  task automatic do_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                           input int w, input bit keep);
    exp_t       e;
    bit         timed_out;
    bit         done;
    logic [7:0] ack_data;
    timed_out = TO_EN && (w >= int'(T));
    ack_data  = we ? 8'($urandom) : mem_value(a);
    if (!we) last_read = timed_out ? 8'hEA : ack_data;
    else if (!timed_out) mem[a] = wd;
    e.addr = a; e.we = we; e.wd = wd; e.rd = last_read; e.err = timed_out;
    e.cycles = timed_out ? int'(T) : w + 1;
    sb.push_back(e);
    cpuAddressHigh = a[15:8]; cpuAddressLow = a[7:0];
    cpuDataWrite = wd; cpuWrite = we; cpuRequest = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!keep) cpuRequest = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      memAck      = (i == w);
      memReadData = (i == w) ? ack_data : 8'($urandom);
      @(posedge clk); @(negedge clk);
      memAck = 1'b0;
      if (cpuReady) done = 1'b1;
    end
    n_checks++;
    if (done) n_pass++;
    else $display("FAIL access_bound: cpuReady=%0b, required 1 within 300 cycles", cpuReady);
  endtask

  // Monitor: checks captured fields on each accept and the result on each completion.
  initial begin
    bit   prev_ready;
    int   low_cnt;
    exp_t e;
    prev_ready = 1'b1;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_ready = 1'b1;
        low_cnt = 0;
      end else begin
        if (prev_ready && !cpuReady) begin
          if (sb.size() == 0) begin
            check("unexpected_capture", 32'(cpuReady), 32'd1);
          end else begin
            check("cap_addr", 32'(memAddress), 32'(sb[0].addr));
            check("cap_we", 32'(memWrite), 32'(sb[0].we));
            if (sb[0].we) check("cap_wdata", 32'(memWriteData), 32'(sb[0].wd));
            check("req_high", 32'(memRequest), 32'd1);
          end
          low_cnt = 0;
        end
        if (!cpuReady) low_cnt++;
        if (!prev_ready && cpuReady) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(cpuReady), 32'd0);
          end else begin
            e = sb.pop_front();
            check("busy_cycles", 32'(low_cnt), 32'(e.cycles));
            check("read_data", 32'(cpuDataRead), 32'(e.rd));
            check("bus_error", 32'(busError), 32'(e.err));
            check("req_low", 32'(memRequest), 32'd0);
          end
        end else if (busError) begin
          check("stray_bus_error", 32'(busError), 32'd0);
        end
        prev_ready = cpuReady;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [15:0] a;
    logic        we;
    int          w;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cpuReady), 32'd1);
    check("rst_memreq", 32'(memRequest), 32'd0);
    check("rst_rdata", 32'(cpuDataRead), 32'h00);
    check("rst_addr", 32'(memAddress), 32'h0000);
    check("rst_wdata", 32'(memWriteData), 32'h00);
    check("rst_we", 32'(memWrite), 32'd0);
    check("rst_buserr", 32'(busError), 32'd0);
    #2 nrst = 1'b1;
    @(negedge clk);

    mem[16'hFFFC] = 8'h34;
    do_access(16'hFFFC, 1'b0, 8'h00, 1, 1'b0);
    check("read_fffc", 32'(cpuDataRead), 32'h34);
    do_access(16'h0200, 1'b1, 8'h5A, 3, 1'b0);
    check("write_keeps_rdata", 32'(cpuDataRead), 32'h34);

    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hA2; mem[16'h0012] = 8'hA3;
    do_access(16'h0010, 1'b0, 8'h00, 0, 1'b1);
    do_access(16'h0011, 1'b0, 8'h00, 0, 1'b1);
    do_access(16'h0012, 1'b0, 8'h00, 0, 1'b0);

    do_access(16'h0300, 1'b0, 8'h00, int'(T) + 4, 1'b0);
    mem[16'h0301] = 8'h77;
    do_access(16'h0301, 1'b0, 8'h00, int'(T) - 1, 1'b0);
    do_access(16'h0302, 1'b1, 8'hC3, int'(T) + 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a  = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) w = int'($urandom_range(T - 2, T + 3));
      else w = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) a = {8'h04, 4'h0, a[3:0]};
      do_access(a, we, 8'($urandom), w, (n != 39) && ($urandom_range(0, 2) == 0));
    end

    memAck = 1'b1; memReadData = 8'hFF;
    @(posedge clk); @(negedge clk);
    memAck = 1'b0;
    check("idle_ack_rdata", 32'(cpuDataRead), 32'(last_read));
    check("idle_ack_ready", 32'(cpuReady), 32'd1);
    check("idle_ack_memreq", 32'(memRequest), 32'd0);
    check("idle_ack_buserr", 32'(busError), 32'd0);

    e.addr = 16'h1234; e.we = 1'b0; e.wd = 8'h00; e.rd = 8'h00; e.err = 1'b0; e.cycles = 0;
    sb.push_back(e);
    cpuAddressHigh = 8'h12; cpuAddressLow = 8'h34; cpuWrite = 1'b0; cpuRequest = 1'b1;
    @(posedge clk); @(negedge clk);
    cpuRequest = 1'b0;
    repeat (2) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_memreq", 32'(memRequest), 32'd0);
    check("mid_rst_ready", 32'(cpuReady), 32'd1);
    check("mid_rst_rdata", 32'(cpuDataRead), 32'h00);
    check("mid_rst_addr", 32'(memAddress), 32'h0000);
    sb.delete();
    last_read = 8'h00;
    @(negedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);
    memAck = 1'b1; memReadData = 8'h99;
    @(negedge clk);
    memAck = 1'b0;
    @(negedge clk);
    check("post_rst_ack_rdata", 32'(cpuDataRead), 32'h00);
    check("post_rst_ack_ready", 32'(cpuReady), 32'd1);
    check("post_rst_ack_memreq", 32'(memRequest), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
